// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a small prefetch FIFO.
// Drives the fetch PC to instruction memory, captures the returned word and
// hands {pc, instr, fault} entries to decode over a valid/ready handshake.
// A redirect flushes the FIFO and restarts fetch at a new PC.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When it is defined, a
// misaligned redirect target produces a single fault entry and fetch halts.
// When it is undefined, redirect targets are force-aligned and out_fault is 0.
module fetch_unit #(
  parameter int             N        = 32,
  parameter int             A        = 32,
  parameter logic [A-1:0]   RESET_PC = '0,
  parameter int             DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [A-1:0] imem_addr,
  input  logic [N-1:0] imem_data,
  input  logic         redirect_valid,
  input  logic [A-1:0] redirect_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_instr,
  output logic [A-1:0] out_pc,
  output logic         out_fault
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [A-1:0]  PC_STEP  = A'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;
`else
  typedef enum logic {S_RUN = 1'b0} state_t;
`endif

  state_t         r_state;
  state_t         w_nextState;
  logic [A-1:0]   r_fetchPc;
  logic [PW:0]    r_rdPtr;
  logic [PW:0]    r_wrPtr;
  logic [PW:0]    r_count;
  logic [A-1:0]   r_memPc    [DEPTH];
  logic [N-1:0]   r_memInstr [DEPTH];
  logic           w_pop;
  logic           w_push;
  logic           w_room;
  logic [A-1:0]   w_redirPc;
  logic [N-1:0]   w_wrInstr;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic           r_memFault [DEPTH];
  logic           w_pushFault;
`else
  logic           w_unusedRedirLow;
`endif

  assign imem_addr = r_fetchPc;
  assign out_valid = (r_count != '0);
  assign out_pc    = r_memPc[r_rdPtr[PW-1:0]];
  assign out_instr = r_memInstr[r_rdPtr[PW-1:0]];
  assign w_pop     = out_valid && out_ready;
  assign w_room    = (r_count != CNT_FULL) || w_pop;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign out_fault = r_memFault[r_rdPtr[PW-1:0]];
  assign w_redirPc = redirect_pc;
  assign w_wrInstr = w_pushFault ? '0 : imem_data;
`else
  assign out_fault        = 1'b0;
  assign w_redirPc        = {redirect_pc[A-1:2], 2'b00};
  assign w_wrInstr        = imem_data;
  assign w_unusedRedirLow = ^redirect_pc[1:0];
`endif

  // Decide whether this cycle pushes a fetched word (or a fault marker) and the next FSM state
  always_comb begin
    w_nextState = r_state;
    w_push      = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    w_pushFault = 1'b0;
`endif
    if (redirect_valid) begin
      w_nextState = S_RUN;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_room) begin
            w_push = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (r_fetchPc[1:0] != 2'b00) begin
              w_pushFault = 1'b1;
              w_nextState = S_HALT;
            end
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Fetch PC, FIFO pointers and occupancy; redirect outranks push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetchPc <= RESET_PC;
      r_rdPtr   <= '0;
      r_wrPtr   <= '0;
      r_count   <= '0;
    end else if (redirect_valid) begin
      r_fetchPc <= w_redirPc;
      r_rdPtr   <= '0;
      r_wrPtr   <= '0;
      r_count   <= '0;
    end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (w_push && !w_pushFault) begin
        r_fetchPc <= r_fetchPc + PC_STEP;
      end
`else
      if (w_push) begin
        r_fetchPc <= r_fetchPc + PC_STEP;
      end
`endif
      if (w_push) begin
        r_wrPtr <= r_wrPtr + CNT_ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + CNT_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

  // FIFO storage; cleared on reset so the head outputs are never X
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_memPc[i]    <= '0;
        r_memInstr[i] <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
        r_memFault[i] <= 1'b0;
`endif
      end
    end else if (!redirect_valid && w_push) begin
      r_memPc[r_wrPtr[PW-1:0]]    <= r_fetchPc;
      r_memInstr[r_wrPtr[PW-1:0]] <= w_wrInstr;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_memFault[r_wrPtr[PW-1:0]] <= w_pushFault;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed testbench for fetch_unit with a combinational
// instruction memory model (word at address a is ((a>>2)<<7) + 0x13).
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;

  int passCount  = 0;
  int checkCount = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_fault      (out_fault)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return ((a >> 2) << 7) + 32'h13;
  endfunction

  assign imem_data = memWord(imem_addr);

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic stepCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b0;
    repeat (2) stepCycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b0;
    repeat (2) stepCycle();
    checkCount++; if (imem_addr !== 32'h0) $display("[TB] FAIL reset_addr: got %h want %h", imem_addr, 32'h0); else passCount++;
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", out_valid); else passCount++;
    checkCount++; if (out_instr !== 32'h0) $display("[TB] FAIL reset_instr: got %h want %h", out_instr, 32'h0); else passCount++;
    checkCount++; if (out_pc !== 32'h0) $display("[TB] FAIL reset_pc: got %h want %h", out_pc, 32'h0); else passCount++;
    checkCount++; if (out_fault !== 1'b0) $display("[TB] FAIL reset_fault: got %b want 0", out_fault); else passCount++;
  endtask

  task automatic test_stream;
    out_ready = 1'b1;
    rst_n = 1'b1;
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL stream_first_valid: got %b want 0", out_valid); else passCount++;
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      checkCount++; if (out_valid !== 1'b1) $display("[TB] FAIL stream_valid[%0d]: got %b want 1", i, out_valid); else passCount++;
      checkCount++; if (out_pc !== 32'(4 * i)) $display("[TB] FAIL stream_pc[%0d]: got %h want %h", i, out_pc, 32'(4 * i)); else passCount++;
      checkCount++; if (out_instr !== memWord(32'(4 * i))) $display("[TB] FAIL stream_instr[%0d]: got %h want %h", i, out_instr, memWord(32'(4 * i))); else passCount++;
    end
  endtask

  task automatic test_stall;
    applyReset();
    repeat (5) stepCycle();
    checkCount++; if (imem_addr !== 32'h8) $display("[TB] FAIL stall_addr: got %h want %h", imem_addr, 32'h8); else passCount++;
    checkCount++; if (out_valid !== 1'b1) $display("[TB] FAIL stall_valid: got %b want 1", out_valid); else passCount++;
    checkCount++; if (out_pc !== 32'h0) $display("[TB] FAIL stall_head: got %h want %h", out_pc, 32'h0); else passCount++;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkCount++; if (out_pc !== 32'(4 * i)) $display("[TB] FAIL drain_pc[%0d]: got %h want %h", i, out_pc, 32'(4 * i)); else passCount++;
      checkCount++; if (out_instr !== memWord(32'(4 * i))) $display("[TB] FAIL drain_instr[%0d]: got %h want %h", i, out_instr, memWord(32'(4 * i))); else passCount++;
      stepCycle();
    end
  endtask

  task automatic test_redirect;
    out_ready = 1'b0;
    repeat (2) stepCycle();
    checkCount++; if (out_valid !== 1'b1) $display("[TB] FAIL redir_head_visible: got %b want 1", out_valid); else passCount++;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    out_ready = 1'b1;
    stepCycle();
    redirect_valid = 1'b0;
    checkCount++; if (imem_addr !== 32'h100) $display("[TB] FAIL redir_addr0: got %h want %h", imem_addr, 32'h100); else passCount++;
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL redir_flush: got %b want 0", out_valid); else passCount++;
    stepCycle();
    checkCount++; if (imem_addr !== 32'h104) $display("[TB] FAIL redir_addr1: got %h want %h", imem_addr, 32'h104); else passCount++;
    checkCount++; if (out_valid !== 1'b1) $display("[TB] FAIL redir_valid: got %b want 1", out_valid); else passCount++;
    checkCount++; if (out_pc !== 32'h100) $display("[TB] FAIL redir_pc0: got %h want %h", out_pc, 32'h100); else passCount++;
    checkCount++; if (out_instr !== memWord(32'h100)) $display("[TB] FAIL redir_instr0: got %h want %h", out_instr, memWord(32'h100)); else passCount++;
    stepCycle();
    checkCount++; if (out_pc !== 32'h104) $display("[TB] FAIL redir_pc1: got %h want %h", out_pc, 32'h104); else passCount++;
  endtask

  task automatic test_wrap;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    out_ready = 1'b1;
    stepCycle();
    redirect_valid = 1'b0;
    checkCount++; if (imem_addr !== 32'hFFFF_FFF8) $display("[TB] FAIL wrap_addr0: got %h want %h", imem_addr, 32'hFFFF_FFF8); else passCount++;
    stepCycle();
    checkCount++; if (imem_addr !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_addr1: got %h want %h", imem_addr, 32'hFFFF_FFFC); else passCount++;
    stepCycle();
    checkCount++; if (imem_addr !== 32'h0) $display("[TB] FAIL wrap_addr2: got %h want %h", imem_addr, 32'h0); else passCount++;
    checkCount++; if (out_pc !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_head: got %h want %h", out_pc, 32'hFFFF_FFFC); else passCount++;
    stepCycle();
    checkCount++; if (out_pc !== 32'h0) $display("[TB] FAIL wrap_pc0: got %h want %h", out_pc, 32'h0); else passCount++;
    checkCount++; if (out_instr !== 32'h13) $display("[TB] FAIL wrap_instr0: got %h want %h", out_instr, 32'h13); else passCount++;
  endtask

  task automatic test_misalign;
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    out_ready = 1'b1;
    stepCycle();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    checkCount++; if (imem_addr !== 32'h102) $display("[TB] FAIL trap_addr: got %h want %h", imem_addr, 32'h102); else passCount++;
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL trap_flush: got %b want 0", out_valid); else passCount++;
    stepCycle();
    checkCount++; if (out_valid !== 1'b1) $display("[TB] FAIL trap_valid: got %b want 1", out_valid); else passCount++;
    checkCount++; if (out_pc !== 32'h102) $display("[TB] FAIL trap_pc: got %h want %h", out_pc, 32'h102); else passCount++;
    checkCount++; if (out_fault !== 1'b1) $display("[TB] FAIL trap_fault: got %b want 1", out_fault); else passCount++;
    checkCount++; if (out_instr !== 32'h0) $display("[TB] FAIL trap_instr: got %h want %h", out_instr, 32'h0); else passCount++;
    repeat (4) stepCycle();
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL halt_valid: got %b want 0", out_valid); else passCount++;
    checkCount++; if (imem_addr !== 32'h102) $display("[TB] FAIL halt_addr: got %h want %h", imem_addr, 32'h102); else passCount++;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    stepCycle();
    redirect_valid = 1'b0;
    stepCycle();
    checkCount++; if (out_valid !== 1'b1) $display("[TB] FAIL resume_valid: got %b want 1", out_valid); else passCount++;
    checkCount++; if (out_pc !== 32'h200) $display("[TB] FAIL resume_pc: got %h want %h", out_pc, 32'h200); else passCount++;
    checkCount++; if (out_fault !== 1'b0) $display("[TB] FAIL resume_fault: got %b want 0", out_fault); else passCount++;
`else
    checkCount++; if (imem_addr !== 32'h100) $display("[TB] FAIL align_addr: got %h want %h", imem_addr, 32'h100); else passCount++;
    stepCycle();
    checkCount++; if (out_valid !== 1'b1) $display("[TB] FAIL align_valid: got %b want 1", out_valid); else passCount++;
    checkCount++; if (out_pc !== 32'h100) $display("[TB] FAIL align_pc: got %h want %h", out_pc, 32'h100); else passCount++;
    checkCount++; if (out_fault !== 1'b0) $display("[TB] FAIL align_fault: got %b want 0", out_fault); else passCount++;
`endif
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    repeat (3) stepCycle();
    checkCount++; if (out_valid !== 1'b1) $display("[TB] FAIL pre_reset_valid: got %b want 1", out_valid); else passCount++;
    #2;
    rst_n = 1'b0;
    #1;
    checkCount++; if (imem_addr !== 32'h0) $display("[TB] FAIL async_addr: got %h want %h", imem_addr, 32'h0); else passCount++;
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL async_valid: got %b want 0", out_valid); else passCount++;
    checkCount++; if (out_pc !== 32'h0) $display("[TB] FAIL async_pc: got %h want %h", out_pc, 32'h0); else passCount++;
    checkCount++; if (out_instr !== 32'h0) $display("[TB] FAIL async_instr: got %h want %h", out_instr, 32'h0); else passCount++;
    checkCount++; if (out_fault !== 1'b0) $display("[TB] FAIL async_fault: got %b want 0", out_fault); else passCount++;
    stepCycle();
    rst_n = 1'b1;
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_misalign();
    test_async_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
